// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared light encodings, default timing values and the
//               request-priority helper used by traffic_timer/traffic_fsm.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // One-hot light encodings
    localparam logic [2:0] LIGHT_NONE   = 3'b000;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b100;

    // Default timing, shared with the FSM
    localparam int DEFAULT_CLK_PER_SEC = 50_000_000;
    localparam int DEFAULT_GREEN_SEC   = 30;
    localparam int DEFAULT_YELLOW_SEC  = 3;
    localparam int DEFAULT_RED_SEC     = 33;

    // Collapse a possibly multi-hot request to one-hot: RED > YELLOW > GREEN
    function automatic logic [2:0] light_prio(input logic [2:0] req);
        if (req[2])      return LIGHT_RED;
        else if (req[1]) return LIGHT_YELLOW;
        else if (req[0]) return LIGHT_GREEN;
        else             return LIGHT_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_timer_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd
// Description : Combinational 7-bit double-dabble converter producing the
//               tens and ones BCD digits (valid for inputs 0..99).
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd (
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    // Scratch register: [14:11] tens, [10:7] ones, [6:0] binary being shifted in
    logic [14:0] sr;

    // Shift-and-add-3 over all seven input bits
    always_comb begin
        sr = {8'd0, bin};
        for (int i = 0; i < 7; i++) begin
            if (sr[10:7] >= 4'd5) sr[10:7] = sr[10:7] + 4'd3;
            if (sr[14:11] >= 4'd5) sr[14:11] = sr[14:11] + 4'd3;
            sr = sr << 1;
        end
        tens = sr[14:11];
        ones = sr[10:7];
    end

endmodule
`default_nettype wire

// File: rtl/traffic_timer.sv
`default_nettype none
// ============================================================================
// Module      : traffic_timer
// Description : One-second prescaler plus per-phase seconds countdown feeding
//               traffic_fsm, with pending reload capture and a registered
//               two-digit BCD display of the remaining seconds.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_timer
    import traffic_pkg::*;
#(
    parameter int LIGHT_STATE_WIDTH = 3,
    parameter int CLK_PER_SEC       = DEFAULT_CLK_PER_SEC,
    parameter int CNT_WIDTH         = 7,
    parameter int GREEN_SEC         = DEFAULT_GREEN_SEC,
    parameter int YELLOW_SEC        = DEFAULT_YELLOW_SEC,
    parameter int RED_SEC           = DEFAULT_RED_SEC
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [LIGHT_STATE_WIDTH-1:0] light_cnt_init,
    output logic                         second_cnt_pre_last,
    output logic                         light_cnt_last,
    output logic                         second_tick,
    output logic [CNT_WIDTH-1:0]         light_cnt,
    output logic [3:0]                   disp_tens,
    output logic [3:0]                   disp_ones
);

    localparam int SEC_W = $clog2(CLK_PER_SEC);
    localparam logic [SEC_W-1:0] SEC_LAST     = SEC_W'(CLK_PER_SEC - 1);
    localparam logic [SEC_W-1:0] SEC_PRE_LAST = SEC_W'(CLK_PER_SEC - 2);

    // Reload values: the counter holds remaining seconds after the current one
    localparam logic [CNT_WIDTH-1:0] GREEN_LOAD  = CNT_WIDTH'(GREEN_SEC - 1);
    localparam logic [CNT_WIDTH-1:0] YELLOW_LOAD = CNT_WIDTH'(YELLOW_SEC - 1);
    localparam logic [CNT_WIDTH-1:0] RED_LOAD    = CNT_WIDTH'(RED_SEC - 1);

    logic [SEC_W-1:0]     sec_cnt;
    logic [2:0]           pend;
    logic [2:0]           req_now;
    logic [2:0]           req_eff;
    logic                 wrap;
    logic [CNT_WIDTH-1:0] load_val;
    logic [6:0]           disp_bin;
    logic [3:0]           bcd_tens;
    logic [3:0]           bcd_ones;

    assign req_now = light_prio(light_cnt_init[2:0]);
    // A live request always wins over an older pending one
    assign req_eff = (req_now != LIGHT_NONE) ? req_now : pend;
    assign wrap    = en && (sec_cnt == SEC_LAST);

    assign second_tick         = wrap;
    assign second_cnt_pre_last = en && (sec_cnt == SEC_PRE_LAST);
    assign light_cnt_last      = (light_cnt == '0);

    // Select the phase duration for the effective request
    always_comb begin
        load_val = '0;
        if (req_eff[2])      load_val = RED_LOAD;
        else if (req_eff[1]) load_val = YELLOW_LOAD;
        else if (req_eff[0]) load_val = GREEN_LOAD;
    end

    // Prescaler: counts clock cycles within a second, frozen when en is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sec_cnt <= '0;
        else if (en)
            sec_cnt <= (sec_cnt == SEC_LAST) ? '0 : sec_cnt + SEC_W'(1);
    end

    // Seconds countdown and pending-request capture; reloads only on a wrap edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            light_cnt <= '0;
            pend      <= LIGHT_NONE;
        end else if (wrap) begin
            if (req_eff != LIGHT_NONE) begin
                light_cnt <= load_val;
                pend      <= LIGHT_NONE;
            end else if (light_cnt != '0) begin
                light_cnt <= light_cnt - CNT_WIDTH'(1);
            end
        end else if (req_now != LIGHT_NONE) begin
            pend <= req_now;
        end
    end

    // Display shows the current second too, hence the +1
    assign disp_bin = 7'(light_cnt + CNT_WIDTH'(1));

    bin2bcd u_bin2bcd (
        .bin  (disp_bin),
        .tens (bcd_tens),
        .ones (bcd_ones)
    );

    // Register the BCD digits (one cycle behind light_cnt)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_tens <= 4'd0;
            disp_ones <= 4'd0;
        end else begin
            disp_tens <= bcd_tens;
            disp_ones <= bcd_ones;
        end
    end

endmodule
`default_nettype wire
